// File: rtl/median_pkg.sv
// Shared defaults, FSM state encoding and sizing helper for the 3x3 median
// window controller and its line buffers.
package median_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int FILTER_LAT_DEF = 3;
  localparam int H_ACTIVE_DEF   = 1280;
  localparam int V_ACTIVE_DEF   = 720;

  // Frame sequencer states, kept as plain constants so older tools that
  // dislike enums in ports and parameters can still consume them.
  typedef logic [0:0] state_t;
  localparam state_t WAIT_VS = 1'b0;
  localparam state_t ACTIVE  = 1'b1;

  // Index width for a counter or address covering 0..depth-1.
  // The result is never below 1 bit.
  function automatic int idx_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/median_line_buf.sv
// One video line of storage for the median window.
// The write is synchronous. The read is combinational, so a read and a write
// at the same address in one cycle return the old contents (read-before-write).
module median_line_buf
  import median_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = H_ACTIVE_DEF,
  localparam int AW    = idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Store the incoming sample; the contents need no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/median_window_ctrl.sv
// Median filter sequencer.
// Builds the 3x3 window from the pixel stream, hands the taps to the external
// 3-clk median filter, and re-aligns de/hs/vs with the filtered result.
// Optional macro MEDIAN_BORDER_PASS_EN: when defined, border pixels carry the
// delayed raw pixel; otherwise border pixels are blanked to 0.
module median_window_ctrl
  import median_pkg::*;
#(
  parameter int   DATA_W     = DATA_W_DEF,
  parameter int   H_ACTIVE   = H_ACTIVE_DEF,
  parameter int   V_ACTIVE   = V_ACTIVE_DEF,
  parameter int   FILTER_LAT = FILTER_LAT_DEF,
  parameter logic VS_POL     = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              filt_en,
  input  logic              in_de,
  input  logic              in_hs,
  input  logic              in_vs,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] win11,
  output logic [DATA_W-1:0] win12,
  output logic [DATA_W-1:0] win13,
  output logic [DATA_W-1:0] win21,
  output logic [DATA_W-1:0] win22,
  output logic [DATA_W-1:0] win23,
  output logic [DATA_W-1:0] win31,
  output logic [DATA_W-1:0] win32,
  output logic [DATA_W-1:0] win33,
  input  logic [DATA_W-1:0] med_data,
  output logic              out_de,
  output logic              out_hs,
  output logic              out_vs,
  output logic [DATA_W-1:0] out_data,
  output logic              ovf
);

  localparam int COL_W  = idx_w(H_ACTIVE);
  localparam int ROW_W  = idx_w(V_ACTIVE);
  // The taps register plus the filter latency.
  // The output register then adds the last stage.
  localparam int PIPE_D = FILTER_LAT + 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(V_ACTIVE - 1);

  state_t            state;
  logic              vs_prev;
  logic              de_prev;
  logic              line_full;
  logic              filt_en_l;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;

  logic              vs_act;
  logic              vs_edge;
  logic              frame_on;
  logic              de_fall;
  logic [COL_W-1:0]  cur_col;
  logic [ROW_W-1:0]  cur_row;
  logic              cur_full;
  logic              px_wr;
  logic              px_over;
  logic              border_in;
  logic [DATA_W-1:0] lb0_rd;
  logic [DATA_W-1:0] lb1_rd;

  logic [PIPE_D-1:0] de_pipe;
  logic [PIPE_D-1:0] hs_pipe;
  logic [PIPE_D-1:0] vs_pipe;
  logic [PIPE_D-1:0] bd_pipe;
  logic [PIPE_D-1:0] on_pipe;
  logic [DATA_W-1:0] raw_pipe [PIPE_D];

  // A vsync edge takes priority over everything else in the same cycle.
  // A pixel arriving together with that edge is handled as (0,0) of the
  // new frame.
  assign vs_act    = (in_vs == VS_POL);
  assign vs_edge   = vs_act & ~vs_prev;
  assign frame_on  = vs_edge | (state == ACTIVE);
  assign de_fall   = de_prev & ~in_de;
  assign cur_col   = vs_edge ? '0 : col;
  assign cur_row   = vs_edge ? '0 : row;
  assign cur_full  = vs_edge ? 1'b0 : line_full;
  assign px_wr     = in_de & frame_on & ~cur_full;
  assign px_over   = in_de & frame_on & cur_full;
  assign border_in = (cur_row <= ROW_W'(1)) || (cur_col <= COL_W'(1));

  // The frame FSM enters ACTIVE on each vsync edge, including a restart.
  // Only reset returns it to WAIT_VS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       state <= WAIT_VS;
    else if (vs_edge) state <= ACTIVE;
  end

  // Remember the previous vs/de levels for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev <= 1'b0;
      de_prev <= 1'b0;
    end else begin
      vs_prev <= vs_act;
      de_prev <= in_de;
    end
  end

  // At frame start, latch the filter enable and clear the sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_en_l <= 1'b0;
      ovf       <= 1'b0;
    end else if (vs_edge) begin
      filt_en_l <= filt_en;
      ovf       <= 1'b0;
    end else if (px_over) begin
      ovf <= 1'b1;
    end
  end

  // Track the pixel position.
  // After the last column, col holds and line_full marks any further pixels
  // on that line as overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      line_full <= 1'b0;
    end else if (px_wr) begin
      row <= cur_row;
      if (cur_col == COL_MAX) begin
        col       <= cur_col;
        line_full <= 1'b1;
      end else begin
        col       <= cur_col + 1'b1;
        line_full <= 1'b0;
      end
    end else if (vs_edge) begin
      col       <= '0;
      row       <= '0;
      line_full <= 1'b0;
    end else if (frame_on && de_fall) begin
      col       <= '0;
      line_full <= 1'b0;
      if (row != ROW_MAX) row <= row + 1'b1;
    end
  end

  // lb1 holds the previous line and lb0 the line before it.
  // Each pixel moves the column down one buffer.
  median_line_buf #(.DATA_W(DATA_W), .DEPTH(H_ACTIVE)) u_lb1 (
    .clk   (clk),
    .we    (px_wr),
    .waddr (cur_col),
    .wdata (in_data),
    .raddr (cur_col),
    .rdata (lb1_rd)
  );

  median_line_buf #(.DATA_W(DATA_W), .DEPTH(H_ACTIVE)) u_lb0 (
    .clk   (clk),
    .we    (px_wr),
    .waddr (cur_col),
    .wdata (lb1_rd),
    .raddr (cur_col),
    .rdata (lb0_rd)
  );

  // Shift the 3x3 window left by one column per accepted pixel.
  // The newest column enters on the right (win13/win23/win33).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win11 <= '0; win12 <= '0; win13 <= '0;
      win21 <= '0; win22 <= '0; win23 <= '0;
      win31 <= '0; win32 <= '0; win33 <= '0;
    end else if (px_wr) begin
      win11 <= win12; win12 <= win13; win13 <= lb0_rd;
      win21 <= win22; win22 <= win23; win23 <= lb1_rd;
      win31 <= win32; win32 <= win33; win33 <= in_data;
    end
  end

  // Carry sync, the raw pixel and the border/active flags alongside the
  // window and filter stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_pipe <= '0;
      hs_pipe <= '0;
      vs_pipe <= '0;
      bd_pipe <= '0;
      on_pipe <= '0;
      for (int i = 0; i < PIPE_D; i++) raw_pipe[i] <= '0;
    end else begin
      de_pipe     <= {de_pipe[PIPE_D-2:0], in_de};
      hs_pipe     <= {hs_pipe[PIPE_D-2:0], in_hs};
      vs_pipe     <= {vs_pipe[PIPE_D-2:0], in_vs};
      bd_pipe     <= {bd_pipe[PIPE_D-2:0], border_in};
      on_pipe     <= {on_pipe[PIPE_D-2:0], frame_on};
      raw_pipe[0] <= in_data;
      for (int i = 1; i < PIPE_D; i++) raw_pipe[i] <= raw_pipe[i-1];
    end
  end

  // Final stage: select blanking, bypass, border handling or the median.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_de   <= 1'b0;
      out_hs   <= 1'b0;
      out_vs   <= 1'b0;
      out_data <= '0;
    end else begin
      out_de <= de_pipe[PIPE_D-1];
      out_hs <= hs_pipe[PIPE_D-1];
      out_vs <= vs_pipe[PIPE_D-1];
      if (!de_pipe[PIPE_D-1] || !on_pipe[PIPE_D-1]) begin
        out_data <= '0;
      end else if (!filt_en_l) begin
        out_data <= raw_pipe[PIPE_D-1];
      end else if (bd_pipe[PIPE_D-1]) begin
`ifdef MEDIAN_BORDER_PASS_EN
        out_data <= raw_pipe[PIPE_D-1];
`else
        out_data <= '0;
`endif
      end else begin
        out_data <= med_data;
      end
    end
  end

endmodule

// File: tb/tb_median_window_ctrl.sv
// Directed bench for median_window_ctrl on an 8x6 frame.
// A 3-clk sorting median model acts as the external filter.
// Border expectations follow the MEDIAN_BORDER_PASS_EN macro.
module tb_median_window_ctrl;

  localparam int HN = 4096;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       filt_en;
  logic       in_de;
  logic       in_hs;
  logic       in_vs;
  logic [7:0] in_data;
  logic [7:0] med_data = 8'h00;
  logic [7:0] s1 = 8'h00;
  logic [7:0] s2 = 8'h00;
  logic [7:0] win11, win12, win13, win21, win22, win23, win31, win32, win33;
  logic       out_de, out_hs, out_vs, ovf;
  logic [7:0] out_data;

  logic [2:0]  h_ctl_in  [HN];
  logic [2:0]  h_ctl_out [HN];
  logic [7:0]  h_din     [HN];
  logic [7:0]  h_dout    [HN];
  logic [71:0] h_win     [HN];
  logic        h_ovf     [HN];
  int          px_cyc    [6][10];
  int          cyc   = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  median_window_ctrl #(
    .DATA_W(8), .H_ACTIVE(8), .V_ACTIVE(6), .FILTER_LAT(3), .VS_POL(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .filt_en(filt_en),
    .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs), .in_data(in_data),
    .win11(win11), .win12(win12), .win13(win13),
    .win21(win21), .win22(win22), .win23(win23),
    .win31(win31), .win32(win32), .win33(win33),
    .med_data(med_data),
    .out_de(out_de), .out_hs(out_hs), .out_vs(out_vs),
    .out_data(out_data), .ovf(ovf)
  );

  function automatic logic [7:0] median9(input logic [71:0] w);
    logic [7:0] a [9];
    logic [7:0] t;
    for (int i = 0; i < 9; i++) a[i] = w[i*8 +: 8];
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    return a[4];
  endfunction

  // External median filter: three register stages after the taps.
  always @(posedge clk) begin
    s1       <= median9({win11, win12, win13, win21, win22, win23, win31, win32, win33});
    s2       <= s1;
    med_data <= s2;
  end

  function automatic logic [7:0] pix(input int mode, input int r, input int c);
    case (mode)
      0:       return 8'(r * 8 + c);
      1:       return (r == 3 && c == 3) ? 8'hFF : 8'h80;
      default: return (r < 2 || c < 2) ? 8'h55 : 8'h20;
    endcase
  endfunction

  function automatic logic [7:0] bexp(input logic [7:0] raw);
`ifdef MEDIAN_BORDER_PASS_EN
    return raw;
`else
    return 8'h00 & raw;
`endif
  endfunction

  function automatic int ctl_errs(input int from, input int to);
    int n = 0;
    for (int c = from; c + 5 < to; c++)
      if (h_ctl_out[c+5] !== h_ctl_in[c]) n++;
    return n;
  endfunction

  task automatic check_output(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: log what is on the wires this cycle, then advance.
  task automatic apply_stimulus();
    h_ctl_in[cyc]  = {in_de, in_hs, in_vs};
    h_din[cyc]     = in_data;
    h_ctl_out[cyc] = {out_de, out_hs, out_vs};
    h_dout[cyc]    = out_data;
    h_win[cyc]     = {win11, win12, win13, win21, win22, win23, win31, win32, win33};
    h_ovf[cyc]     = ovf;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= HN) begin
      $display("[TB] FAIL history_budget observed=%0d limit=%0d", cyc, HN);
      $fatal(1, "[TB] cycle budget exhausted");
    end
  endtask

  task automatic line_blank();
    in_de = 1'b0; in_data = 8'h00; in_hs = 1'b1;
    apply_stimulus(); apply_stimulus();
    in_hs = 1'b0;
    apply_stimulus(); apply_stimulus();
  endtask

  task automatic vs_pulse(output int v);
    v = cyc;
    in_vs = 1'b1;
    apply_stimulus(); apply_stimulus();
    in_vs = 1'b0;
    repeat (3) apply_stimulus();
  endtask

  task automatic send_line(input int mode, input int r, input int n);
    for (int c = 0; c < n; c++) begin
      in_de = 1'b1;
      in_data = pix(mode, r, c);
      if (c < 10) px_cyc[r][c] = cyc;
      apply_stimulus();
    end
    line_blank();
  endtask

  task automatic send_frame(input int mode, output int v);
    vs_pulse(v);
    for (int r = 0; r < 6; r++) send_line(mode, r, 8);
    repeat (8) apply_stimulus();
  endtask

  initial begin
    int v, p, cnt, rel, endq;
    rst_n = 1'b0; filt_en = 1'b0;
    in_de = 1'b0; in_hs = 1'b0; in_vs = 1'b0; in_data = 8'h00;
    repeat (3) apply_stimulus();
    check_output("reset_out", 72'({out_de, out_hs, out_vs, ovf, out_data}), 72'h0);
    check_output("reset_win", {win11, win12, win13, win21, win22, win23, win31, win32, win33}, 72'h0);
    rst_n = 1'b1;
    repeat (2) apply_stimulus();

    // Ramp frame, filtering on
    filt_en = 1'b1;
    send_frame(0, v);
    p = px_cyc[2][2];
    check_output("win_2_2", h_win[p+1], 72'h00_01_02_08_09_0A_10_11_12);
    check_output("ramp_2_2_lat5", 72'(h_dout[p+5]), 72'd9);
    check_output("ramp_2_2_lat4", 72'(h_dout[p+4]), 72'(bexp(8'd17)));
    check_output("ramp_4_5", 72'(h_dout[px_cyc[4][5]+5]), 72'd28);
    check_output("border_0_5", 72'(h_dout[px_cyc[0][5]+5]), 72'(bexp(8'd5)));
    check_output("border_3_1", 72'(h_dout[px_cyc[3][1]+5]), 72'(bexp(8'd25)));
    check_output("ctl_delay_f1", 72'(ctl_errs(v, cyc)), 72'd0);
    check_output("ovf_f1", 72'(ovf), 72'd0);

    // Asynchronous reset in the middle of a line
    vs_pulse(v);
    send_line(0, 0, 8);
    send_line(0, 1, 8);
    for (int c = 0; c < 4; c++) begin
      in_de = 1'b1; in_data = pix(0, 2, c); apply_stimulus();
    end
    rst_n = 1'b0;
    #1;
    check_output("async_reset_out", 72'({out_de, out_hs, out_vs, ovf, out_data}), 72'h0);
    check_output("async_reset_win", {win11, win12, win13, win21, win22, win23, win31, win32, win33}, 72'h0);
    for (int c = 4; c < 6; c++) begin
      in_de = 1'b1; in_data = pix(0, 2, c); apply_stimulus();
    end
    rst_n = 1'b1;
    rel = cyc;
    for (int c = 6; c < 8; c++) begin
      in_de = 1'b1; in_data = pix(0, 2, c); apply_stimulus();
    end
    line_blank();
    send_line(0, 3, 8);
    repeat (6) apply_stimulus();
    endq = cyc;
    cnt = 0;
    for (int c = rel; c < endq; c++)
      if (h_dout[c] !== 8'h00 || h_win[c] !== 72'h0 || h_ovf[c] !== 1'b0) cnt++;
    check_output("wait_vs_quiet", 72'(cnt), 72'd0);
    check_output("wait_vs_ctl", 72'(ctl_errs(rel, endq)), 72'd0);

    // Flat frame with one impulse; also the first frame after the reset
    send_frame(1, v);
    p = px_cyc[0][0];
    cnt = 0;
    for (int c = v; c < p + 5; c++) if (h_dout[c] !== 8'h00) cnt++;
    check_output("first_px_lat", 72'(cnt), 72'd0);
    check_output("first_px_out", 72'(h_dout[p+5]), 72'(bexp(8'h80)));
    cnt = 0;
    for (int r = 2; r < 6; r++)
      for (int c = 2; c < 8; c++)
        if (h_dout[px_cyc[r][c]+5] !== 8'h80) cnt++;
    check_output("impulse_interior", 72'(cnt), 72'd0);
    check_output("impulse_4_4", 72'(h_dout[px_cyc[4][4]+5]), 72'h80);
    check_output("ctl_delay_f3", 72'(ctl_errs(v, cyc)), 72'd0);

    // Border ring of 0x55 around a 0x20 interior
    send_frame(2, v);
    check_output("border_0_0", 72'(h_dout[px_cyc[0][0]+5]), 72'(bexp(8'h55)));
    check_output("border_1_5", 72'(h_dout[px_cyc[1][5]+5]), 72'(bexp(8'h55)));
    check_output("border_4_1", 72'(h_dout[px_cyc[4][1]+5]), 72'(bexp(8'h55)));
    check_output("interior_2_2", 72'(h_dout[px_cyc[2][2]+5]), 72'h55);
    check_output("interior_3_3", 72'(h_dout[px_cyc[3][3]+5]), 72'h55);
    check_output("interior_4_4", 72'(h_dout[px_cyc[4][4]+5]), 72'h20);

    // Bypass latched at the frame start, enable raised mid-frame
    filt_en = 1'b0;
    vs_pulse(v);
    for (int r = 0; r < 3; r++) send_line(0, r, 8);
    filt_en = 1'b1;
    for (int r = 3; r < 6; r++) send_line(0, r, 8);
    repeat (8) apply_stimulus();
    cnt = 0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 8; c++)
        if (h_dout[px_cyc[r][c]+5] !== pix(0, r, c)) cnt++;
    check_output("bypass_frame", 72'(cnt), 72'd0);
    check_output("bypass_4_4", 72'(h_dout[px_cyc[4][4]+5]), 72'd36);
    send_frame(0, v);
    check_output("refilter_4_4", 72'(h_dout[px_cyc[4][4]+5]), 72'd27);

    // Overlong line
    vs_pulse(v);
    for (int c = 0; c < 10; c++) begin
      in_de = 1'b1; in_data = pix(0, 0, c); px_cyc[0][c] = cyc;
      apply_stimulus();
      if (c == 7) check_output("ovf_pix8", 72'(ovf), 72'd0);
      if (c == 8) check_output("ovf_pix9", 72'(ovf), 72'd1);
    end
    line_blank();
    send_line(0, 1, 8);
    check_output("ovf_sticky", 72'(ovf), 72'd1);
    in_vs = 1'b1;
    apply_stimulus();
    check_output("ovf_clear", 72'(ovf), 72'd0);
    apply_stimulus();
    in_vs = 1'b0;
    repeat (4) apply_stimulus();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
